armleocpu_ptw_arbiter: RTL
==========================

ARMLEOCPU_PTW_ARBITER -- requirements
Module: armleocpu_ptw_arbiter

Interface
REQ-001 SHALL have clk, input, 1: clock; all state changes on rising edge.
REQ-002 SHALL have rst_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have r0_request / r1_request, input, 1 each: translation request from port 0 (data MMU) and port 1 (fetch MMU).
REQ-004 SHALL have r0_virtual_address / r1_virtual_address, input, 20 each: VPN[1:0] of the request.
REQ-005 SHALL have r0_ack / r1_ack, output, 1 each: request accepted (grant) pulse.
REQ-006 SHALL have r0_done / r1_done, output, 1 each: result-valid pulse for that port.
REQ-007 SHALL have res_pagefault, res_accessfault (output, 1 each), res_access_bits (output, 8) and res_physical_address (output, 22): shared registered result bus, valid only while an rN_done is high.
REQ-008 SHALL have ptw_resolve_request (output, 1), ptw_virtual_address (output, 20), ptw_resolve_ack (input, 1), ptw_resolve_done, ptw_resolve_pagefault, ptw_resolve_accessfault (input, 1 each), ptw_resolve_access_bits (input, 8) and ptw_resolve_physical_address (input, 22): page table walker side.
REQ-009 SHALL have flush (input, 1): kill the in-flight translation; busy (output, 1): state != IDLE.

Function
REQ-010 SHALL implement states IDLE, ISSUE and WAIT.
REQ-011 SHALL, in IDLE with at least one rN_request high, grant one port, latch its virtual address into saved_va, and move to ISSUE.
REQ-012 SHALL grant the single requester when only one requests; when both request, SHALL grant the port not granted last (round-robin), tracked by register last_grant.
REQ-013 SHALL pulse rN_ack high for exactly one cycle, the first ISSUE cycle, for the granted port only; requesters drop request on seeing ack.
REQ-014 SHALL ignore rN_request in ISSUE and WAIT; requests are sampled only in IDLE.
REQ-015 SHALL drive ptw_resolve_request = (state==ISSUE) && !flush; ptw_virtual_address = saved_va at all times.
REQ-016 SHALL move ISSUE->WAIT on the edge where ptw_resolve_request && ptw_resolve_ack, and hold ISSUE while ack is low.
REQ-017 SHALL, in WAIT on ptw_resolve_done, register the PTW result fields onto res_* and pulse the granted port's rN_done for one cycle (the cycle after done), then return to IDLE.
REQ-018 SHALL hold res_* stable between done pulses and never assert r0_done and r1_done together.
REQ-019 SHALL, on flush in ISSUE, return to IDLE without issuing (no ptw request that cycle) and without a done pulse.
REQ-020 SHALL, on flush in WAIT (any cycle including the done cycle), set killed; it SHALL keep waiting for ptw_resolve_done (the walk cannot be aborted), then return to IDLE with no rN_done, leaving res_* unchanged.
REQ-021 SHALL treat flush in IDLE as no-op; a request present with flush in IDLE is still granted.
REQ-022 SHALL allow a new grant in the IDLE cycle immediately following a done or killed completion (minimum 1 IDLE cycle between transactions).
REQ-023 SHALL update last_grant only on grant, not on completion or flush.

Reset
REQ-024 SHALL on rst_n low: state=IDLE, last_grant=1 (port 0 wins first tie), killed=0, r0/r1_ack=0, r0/r1_done=0, res_pagefault=0, res_accessfault=0, res_access_bits=0, res_physical_address=0, saved_va=0.
REQ-025 SHALL, on reset asserted mid-walk, drop to IDLE without any done pulse; the system resets the PTW on the same rst_n.

Verification
REQ-026 Single: r0_request, va=0x12345, ack same cycle, done 3 cycles later with phys=0x0ABCD, bits=0xCF -> r0_ack one pulse, ptw_virtual_address=0x12345, r0_done one pulse with res_physical_address=0x0ABCD, res_access_bits=0xCF.
REQ-027 Tie after reset: both request -> port 0 granted first; both request again -> port 1 granted; third tie -> port 0.
REQ-028 Backpressure: ptw_resolve_ack low 4 cycles in ISSUE -> request held, va stable, no state change; WAIT entered on the edge ack goes high.
REQ-029 Flush in WAIT: flush 1 cycle after ack, done 2 cycles later with pagefault=1 -> no r0_done/r1_done, res_* unchanged, busy low after done, next request granted.
REQ-030 Flush in ISSUE with ptw_resolve_ack high same cycle -> ptw_resolve_request low, return to IDLE, no done pulse.
REQ-031 Reset during WAIT -> all outputs at reset values next cycle; a subsequent tie grants port 0.

Source files
------------

// File: rtl/armleocpu_ptw_arbiter_if.sv
// ---------------------------------------------------------------------------
// armleocpu_ptw_arbiter_if
//
// Bundles every handshake/bus signal of the page-table-walker arbiter so the
// arbiter, the two MMU requesters and the PTW can be wired with one port.
//
// Signal groups:
//   r0_* / r1_*   : translation request ports (0 = data MMU, 1 = fetch MMU)
//                   request, virtual_address[19:0] in; ack, done out
//   res_*         : shared registered result bus (valid while an rN_done
//                   is high): pagefault, accessfault, access_bits[7:0],
//                   physical_address[21:0]
//   ptw_*         : page table walker side: resolve_request and
//                   virtual_address[19:0] out; resolve_ack, resolve_done,
//                   resolve_pagefault, resolve_accessfault,
//                   resolve_access_bits[7:0], resolve_physical_address[21:0]
//                   in
//   flush / busy  : kill the in-flight translation / arbiter not idle
//
// Modports:
//   slave  : the arbiter's view (requests and PTW results come in)
//   master : the surrounding system's view (drives requests, PTW results)
// ---------------------------------------------------------------------------
interface armleocpu_ptw_arbiter_if;
  logic        r0_request;
  logic [19:0] r0_virtual_address;
  logic        r0_ack;
  logic        r0_done;

  logic        r1_request;
  logic [19:0] r1_virtual_address;
  logic        r1_ack;
  logic        r1_done;

  logic        res_pagefault;
  logic        res_accessfault;
  logic [7:0]  res_access_bits;
  logic [21:0] res_physical_address;

  logic        ptw_resolve_request;
  logic [19:0] ptw_virtual_address;
  logic        ptw_resolve_ack;
  logic        ptw_resolve_done;
  logic        ptw_resolve_pagefault;
  logic        ptw_resolve_accessfault;
  logic [7:0]  ptw_resolve_access_bits;
  logic [21:0] ptw_resolve_physical_address;

  logic        flush;
  logic        busy;

  modport slave (
    input  r0_request, r0_virtual_address,
    output r0_ack, r0_done,
    input  r1_request, r1_virtual_address,
    output r1_ack, r1_done,
    output res_pagefault, res_accessfault, res_access_bits, res_physical_address,
    output ptw_resolve_request, ptw_virtual_address,
    input  ptw_resolve_ack, ptw_resolve_done,
    input  ptw_resolve_pagefault, ptw_resolve_accessfault,
    input  ptw_resolve_access_bits, ptw_resolve_physical_address,
    input  flush,
    output busy
  );

  modport master (
    output r0_request, r0_virtual_address,
    input  r0_ack, r0_done,
    output r1_request, r1_virtual_address,
    input  r1_ack, r1_done,
    input  res_pagefault, res_accessfault, res_access_bits, res_physical_address,
    input  ptw_resolve_request, ptw_virtual_address,
    output ptw_resolve_ack, ptw_resolve_done,
    output ptw_resolve_pagefault, ptw_resolve_accessfault,
    output ptw_resolve_access_bits, ptw_resolve_physical_address,
    output flush,
    input  busy
  );
endinterface

// File: rtl/armleocpu_ptw_arbiter.sv
// ---------------------------------------------------------------------------
// armleocpu_ptw_arbiter
//
// Shares a single page table walker between the data MMU (port 0) and the
// fetch MMU (port 1). One translation is in flight at a time:
//   IDLE  : sample requests, grant one port (round-robin on a tie), latch
//           its virtual address, pulse that port's ack on the next cycle
//   ISSUE : present the latched address to the PTW until it acknowledges
//   WAIT  : wait for the PTW result, copy it to the shared res_* bus and
//           pulse the granted port's done
// A flush in ISSUE abandons the request before it reaches the PTW. A flush
// in WAIT cannot stop the walk, so the result is awaited and discarded.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset (the PTW shares it)
//   bus    : armleocpu_ptw_arbiter_if.slave, see the interface file
// ---------------------------------------------------------------------------
module armleocpu_ptw_arbiter (
  input  logic                    clk,
  input  logic                    rst_n,
  armleocpu_ptw_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  // Port that won the most recent grant; 1 after reset so port 0 wins the
  // first tie.
  logic        r_last_grant;
  // Port that owns the in-flight translation, selects which done pulses.
  logic        r_granted;
  // Set when the in-flight walk was flushed while waiting for its result.
  logic        r_killed;
  logic [19:0] r_saved_va;

  logic        r_r0_ack;
  logic        r_r1_ack;
  logic        r_r0_done;
  logic        r_r1_done;
  logic        r_res_pagefault;
  logic        r_res_accessfault;
  logic [7:0]  r_res_access_bits;
  logic [21:0] r_res_physical_address;

  logic        w_any_request;
  logic        w_grant0;
  logic        w_discard_result;

  assign w_any_request = bus.r0_request | bus.r1_request;

  // Port 0 wins when it is alone, or on a tie when port 1 won last time.
  assign w_grant0 = bus.r0_request & (~bus.r1_request | r_last_grant);

  // A flush arriving in the same cycle as done still kills the result.
  assign w_discard_result = r_killed | bus.flush;

  // Arbiter FSM; every output except the PTW request/address and busy is
  // registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state                <= IDLE;
      r_last_grant           <= 1'b1;
      r_granted              <= 1'b0;
      r_killed               <= 1'b0;
      r_saved_va             <= '0;
      r_r0_ack               <= 1'b0;
      r_r1_ack               <= 1'b0;
      r_r0_done              <= 1'b0;
      r_r1_done              <= 1'b0;
      r_res_pagefault        <= 1'b0;
      r_res_accessfault      <= 1'b0;
      r_res_access_bits      <= '0;
      r_res_physical_address <= '0;
    end else begin
      // ack and done are single-cycle pulses.
      r_r0_ack  <= 1'b0;
      r_r1_ack  <= 1'b0;
      r_r0_done <= 1'b0;
      r_r1_done <= 1'b0;

      case (r_state)
        IDLE: begin
          // flush is deliberately ignored here.
          if (w_any_request) begin
            r_granted    <= ~w_grant0;
            r_last_grant <= ~w_grant0;
            r_saved_va   <= w_grant0 ? bus.r0_virtual_address
                                     : bus.r1_virtual_address;
            r_r0_ack     <= w_grant0;
            r_r1_ack     <= ~w_grant0;
            r_killed     <= 1'b0;
            r_state      <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus.flush) begin
            r_state <= IDLE;
          end else if (bus.ptw_resolve_ack) begin
            r_state <= WAIT;
          end
        end

        WAIT: begin
          if (bus.ptw_resolve_done) begin
            if (!w_discard_result) begin
              r_res_pagefault        <= bus.ptw_resolve_pagefault;
              r_res_accessfault      <= bus.ptw_resolve_accessfault;
              r_res_access_bits      <= bus.ptw_resolve_access_bits;
              r_res_physical_address <= bus.ptw_resolve_physical_address;
              r_r0_done              <= ~r_granted;
              r_r1_done              <= r_granted;
            end
            r_killed <= 1'b0;
            r_state  <= IDLE;
          end else if (bus.flush) begin
            r_killed <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The PTW request is withdrawn combinationally in a flush cycle so the
  // walker never starts a translation that is already dead.
  assign bus.ptw_resolve_request = (r_state == ISSUE) & ~bus.flush;
  assign bus.ptw_virtual_address = r_saved_va;
  assign bus.busy                = (r_state != IDLE);

  assign bus.r0_ack               = r_r0_ack;
  assign bus.r1_ack               = r_r1_ack;
  assign bus.r0_done              = r_r0_done;
  assign bus.r1_done              = r_r1_done;
  assign bus.res_pagefault        = r_res_pagefault;
  assign bus.res_accessfault      = r_res_accessfault;
  assign bus.res_access_bits      = r_res_access_bits;
  assign bus.res_physical_address = r_res_physical_address;

endmodule
